// File: rtl/qsn_sched_len5.sv
// Two-port round-robin scheduler and configuration sequencer for the Z=5,
// 3-bit-message QSN barrel shifter. Merge select is driven in the accept
// cycle. Data and left/right selects are driven one cycle later. Two tag
// stages mark each result as it leaves the shifter.
module qsn_sched_len5 #(
  parameter int unsigned Z = 5,
  parameter int unsigned Q = 3
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req0_shift,
  input  logic [2:0]       req1_shift,
  input  logic [Z*Q-1:0]   req0_data,
  input  logic [Z*Q-1:0]   req1_data,
  output logic [Z-1:0]     sw_in_bit0,
  output logic [Z-1:0]     sw_in_bit1,
  output logic [Z-1:0]     sw_in_bit2,
  output logic [2:0]       left_sel,
  output logic [2:0]       right_sel,
  output logic [Z-2:0]     merge_sel,
  output logic             out_valid,
  output logic             out_id,
  output logic             out_err,
  output logic             err_shift,
  output logic [1:0]       inflight
);

  localparam logic [2:0] ZS = 3'(Z);

  logic             ptr_q, ptr_d;
  logic [Z*Q-1:0]   data_q, data_d;
  logic [2:0]       left_q, left_d;
  logic [2:0]       right_q, right_d;
  logic             t1_v_q, t1_v_d, t1_id_q, t1_id_d, t1_err_q, t1_err_d;
  logic             t2_v_q, t2_v_d, t2_id_q, t2_id_d, t2_err_q, t2_err_d;
  logic             err_q, err_d;

  logic             accept;
  logic             gnt_id;
  logic [2:0]       sel_shift;
  logic [2:0]       shift_eff;
  logic             illegal;
  logic [Z*Q-1:0]   sel_data;
  logic [Z-2:0]     merge_enc;

  // Round-robin grant. The pointer names the last winner, so on contention the other requester wins.
  always_comb begin
    req_ready = '0;
    if (rstn) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = ptr_q ? 2'b01 : 2'b10;
        default: req_ready = '0;
      endcase
    end
  end

  // Select the granted request. An out-of-range shift is treated as a shift of 0.
  always_comb begin
    accept    = |req_ready;
    gnt_id    = req_ready[1];
    sel_shift = gnt_id ? req1_shift : req0_shift;
    sel_data  = gnt_id ? req1_data : req0_data;
    illegal   = accept && (sel_shift >= ZS);
    shift_eff = (sel_shift >= ZS) ? 3'd0 : sel_shift;
    merge_enc = '0;
    for (int unsigned k = 0; k < Z - 1; k++) begin
      merge_enc[k] = (k + int'(shift_eff)) < (Z - 1);
    end
    merge_sel = accept ? merge_enc : '1;
  end

  // Next state for the dispatch registers, the two tag stages, the pointer and the sticky error flag.
  always_comb begin
    ptr_d    = accept ? gnt_id : ptr_q;
    data_d   = accept ? sel_data : '0;
    left_d   = accept ? shift_eff : '0;
    right_d  = (accept && shift_eff != 3'd0) ? (ZS - shift_eff) : '0;
    t1_v_d   = accept;
    t1_id_d  = accept & gnt_id;
    t1_err_d = illegal;
    t2_v_d   = t1_v_q;
    t2_id_d  = t1_id_q;
    t2_err_d = t1_err_q;
    err_d    = err_q | illegal;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      ptr_q    <= 1'b1;
      data_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      t1_v_q   <= 1'b0;
      t1_id_q  <= 1'b0;
      t1_err_q <= 1'b0;
      t2_v_q   <= 1'b0;
      t2_id_q  <= 1'b0;
      t2_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      left_q   <= left_d;
      right_q  <= right_d;
      t1_v_q   <= t1_v_d;
      t1_id_q  <= t1_id_d;
      t1_err_q <= t1_err_d;
      t2_v_q   <= t2_v_d;
      t2_id_q  <= t2_id_d;
      t2_err_q <= t2_err_d;
      err_q    <= err_d;
    end
  end

  // Output mapping from the registered state.
  always_comb begin
    sw_in_bit0 = data_q[Z-1:0];
    sw_in_bit1 = data_q[2*Z-1:Z];
    sw_in_bit2 = data_q[3*Z-1:2*Z];
    left_sel   = left_q;
    right_sel  = right_q;
    out_valid  = t2_v_q;
    out_id     = t2_id_q;
    out_err    = t2_err_q;
    err_shift  = err_q;
    inflight   = {1'b0, t1_v_q} + {1'b0, t2_v_q};
  end

endmodule

// File: tb/tb_qsn_sched_len5.sv
// Directed table-driven bench for qsn_sched_len5, plus one bounded latency sequence.
module tb_qsn_sched_len5;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req0_shift, req1_shift;
  logic [14:0] req0_data, req1_data;
  logic [4:0]  sw_in_bit0, sw_in_bit1, sw_in_bit2;
  logic [2:0]  left_sel, right_sel;
  logic [3:0]  merge_sel;
  logic        out_valid, out_id, out_err, err_shift;
  logic [1:0]  inflight;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 sys_clk = ~sys_clk;

  qsn_sched_len5 #(.Z(5), .Q(3)) dut (
    .sys_clk    (sys_clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_shift (req0_shift),
    .req1_shift (req1_shift),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .sw_in_bit0 (sw_in_bit0),
    .sw_in_bit1 (sw_in_bit1),
    .sw_in_bit2 (sw_in_bit2),
    .left_sel   (left_sel),
    .right_sel  (right_sel),
    .merge_sel  (merge_sel),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_err    (out_err),
    .err_shift  (err_shift),
    .inflight   (inflight)
  );

  typedef struct {
    logic        rn;
    logic [1:0]  vld;
    logic [2:0]  s0;
    logic [14:0] d0;
    logic [2:0]  s1;
    logic [14:0] d1;
    logic [1:0]  rdy;
    logic [3:0]  msel;
    logic [2:0]  lsel;
    logic [2:0]  rsel;
    logic [14:0] data;
    logic        ov;
    logic        oid;
    logic        oerr;
    logic        errs;
    logic [1:0]  infl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rn, input logic [1:0] vld,
                     input logic [2:0] s0, input logic [14:0] d0,
                     input logic [2:0] s1, input logic [14:0] d1,
                     input logic [1:0] rdy, input logic [3:0] msel,
                     input logic [2:0] lsel, input logic [2:0] rsel,
                     input logic [14:0] data, input logic ov, input logic oid,
                     input logic oerr, input logic errs, input logic [1:0] infl);
    vec_t v;
    v.rn = rn; v.vld = vld; v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1;
    v.rdy = rdy; v.msel = msel; v.lsel = lsel; v.rsel = rsel; v.data = data;
    v.ov = ov; v.oid = oid; v.oerr = oerr; v.errs = errs; v.infl = infl;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
  endtask

  initial begin
    int n;
    rstn = 1'b0; req_valid = '0;
    req0_shift = '0; req1_shift = '0; req0_data = '0; req1_data = '0;
    repeat (3) @(posedge sys_clk);

    //   rn vld  s0 d0        s1 d1        rdy    msel     l  r  data      ov oid oerr errs infl
    // reset held with both valid
    add(0, 2'b11, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    // contention, shifts 1 and 3: grants alternate 0,1,...
    add(1, 2'b11, 1, 15'h1111, 3, 15'h2222, 2'b01, 4'b0111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    add(1, 2'b11, 1, 15'h1111, 3, 15'h2222, 2'b10, 4'b0001, 1, 4, 15'h1111, 0, 0, 0, 0, 1);
    add(1, 2'b11, 1, 15'h1111, 3, 15'h2222, 2'b01, 4'b0111, 3, 2, 15'h2222, 1, 0, 0, 0, 2);
    add(1, 2'b11, 1, 15'h1111, 3, 15'h2222, 2'b10, 4'b0001, 1, 4, 15'h1111, 1, 1, 0, 0, 2);
    add(1, 2'b11, 1, 15'h1111, 3, 15'h2222, 2'b01, 4'b0111, 3, 2, 15'h2222, 1, 0, 0, 0, 2);
    add(1, 2'b11, 1, 15'h1111, 3, 15'h2222, 2'b10, 4'b0001, 1, 4, 15'h1111, 1, 1, 0, 0, 2);
    // idle drain
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 3, 2, 15'h2222, 1, 0, 0, 0, 2);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 1, 1, 0, 0, 1);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    // req0 only, shift 2, data 1234
    add(1, 2'b01, 2, 15'h1234, 0, 15'h0000, 2'b01, 4'b0011, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 2, 3, 15'h1234, 0, 0, 0, 0, 1);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 1, 0, 0, 0, 1);
    // req1 illegal shift 6
    add(1, 2'b10, 0, 15'h0000, 6, 15'h7FFF, 2'b10, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h7FFF, 0, 0, 0, 1, 1);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 1, 1, 1, 1, 1);
    // shift sweep 0..4 from req0
    add(1, 2'b01, 0, 15'h0011, 0, 15'h0000, 2'b01, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 1, 0);
    add(1, 2'b01, 1, 15'h0022, 0, 15'h0000, 2'b01, 4'b0111, 0, 0, 15'h0011, 0, 0, 0, 1, 1);
    add(1, 2'b01, 2, 15'h0033, 0, 15'h0000, 2'b01, 4'b0011, 1, 4, 15'h0022, 1, 0, 0, 1, 2);
    add(1, 2'b01, 3, 15'h0044, 0, 15'h0000, 2'b01, 4'b0001, 2, 3, 15'h0033, 1, 0, 0, 1, 2);
    add(1, 2'b01, 4, 15'h0055, 0, 15'h0000, 2'b01, 4'b0000, 3, 2, 15'h0044, 1, 0, 0, 1, 2);
    // one-cycle reset with inflight=2
    add(0, 2'b01, 1, 15'h0066, 0, 15'h0000, 2'b00, 4'b1111, 4, 1, 15'h0055, 1, 0, 0, 1, 2);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    // pointer back at 1: req0 wins first contention
    add(1, 2'b11, 2, 15'h0ABC, 4, 15'h0DEF, 2'b01, 4'b0011, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    add(1, 2'b11, 2, 15'h0ABC, 4, 15'h0DEF, 2'b10, 4'b0000, 2, 3, 15'h0ABC, 0, 0, 0, 0, 1);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 4, 1, 15'h0DEF, 1, 0, 0, 0, 2);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 1, 1, 0, 0, 1);
    add(1, 2'b00, 0, 15'h0000, 0, 15'h0000, 2'b00, 4'b1111, 0, 0, 15'h0000, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge sys_clk); #1;
      rstn = vq[i].rn; req_valid = vq[i].vld;
      req0_shift = vq[i].s0; req0_data = vq[i].d0;
      req1_shift = vq[i].s1; req1_data = vq[i].d1;
      @(negedge sys_clk);
      chk("req_ready", i, 32'(req_ready), 32'(vq[i].rdy));
      chk("merge_sel", i, 32'(merge_sel), 32'(vq[i].msel));
      chk("left_sel", i, 32'(left_sel), 32'(vq[i].lsel));
      chk("right_sel", i, 32'(right_sel), 32'(vq[i].rsel));
      chk("sw_in", i, 32'({sw_in_bit2, sw_in_bit1, sw_in_bit0}), 32'(vq[i].data));
      chk("out_valid", i, 32'(out_valid), 32'(vq[i].ov));
      chk("out_id", i, 32'(out_id), 32'(vq[i].oid));
      chk("out_err", i, 32'(out_err), 32'(vq[i].oerr));
      chk("err_shift", i, 32'(err_shift), 32'(vq[i].errs));
      chk("inflight", i, 32'(inflight), 32'(vq[i].infl));
    end

    // req1 with shift 5: result must appear exactly two cycles after accept, flagged as error
    @(posedge sys_clk); #1;
    req_valid = 2'b10; req1_shift = 3'd5; req1_data = 15'h3C3C;
    @(negedge sys_clk);
    chk("seq_ready", 100, 32'(req_ready), 32'(2'b10));
    chk("seq_merge", 100, 32'(merge_sel), 32'(4'b1111));
    n = 0;
    do begin
      @(posedge sys_clk); #1;
      req_valid = 2'b00;
      @(negedge sys_clk);
      n++;
    end while (!out_valid && n < 5);
    chk("seq_latency", 101, 32'(n), 32'(2));
    chk("seq_out_id", 101, 32'(out_id), 32'(1'b1));
    chk("seq_out_err", 101, 32'(out_err), 32'(1'b1));
    chk("seq_err_shift", 101, 32'(err_shift), 32'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
